// File: rtl/bp_pkg.sv
// Shared encodings and default sizes for the branch direction predictor.
package bp_pkg;

    // Two-bit saturating counter states, weakest to strongest.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Pattern table entries start weakly not-taken so a cold predictor
    // never redirects fetch, yet one taken outcome is enough to flip it.
    localparam logic [1:0] PHT_RESET = WNT;

    // Default geometry: 256-entry history table, 4-bit local history.
    localparam int BP_INDEX_W = 8;
    localparam int BP_HIST_W  = 4;
    localparam int BP_CNT_W   = 32;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a two-bit saturating direction counter.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cur_i,
    input  logic       taken_i,
    output logic [1:0] nxt_o
);

    // Step toward strongly-taken on taken, toward strongly-not-taken otherwise;
    // the end states absorb further steps in the same direction.
    always_comb begin
        nxt_o = cur_i;
        if (taken_i) begin
            if (cur_i != ST) begin
                nxt_o = cur_i + 2'd1;
            end
        end else begin
            if (cur_i != SNT) begin
                nxt_o = cur_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_direction_predictor.sv
// Two-level local-history branch direction predictor.
// Level 1 (BHT) holds per-PC outcome history; level 2 (PHT) maps a history
// pattern to a two-bit counter. Prediction is combinational in fetch; the
// history used to predict is carried to EX so training hits the same PHT
// entry that produced the prediction.
module branch_direction_predictor
    import bp_pkg::*;
#(
    parameter int index_width = BP_INDEX_W,
    parameter int hist_width  = BP_HIST_W,
    parameter int cnt_width   = BP_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          IF_ID_PC,
    input  logic [31:0]          ID_EX_PC,
    input  logic                 BTB_hit,
    input  logic                 ID_EX_Branch,
    input  logic                 PCSrc,
    input  logic                 Stall,
    input  logic                 Flush,
    output logic                 Predict_taken,
    output logic                 Mispredict,
    output logic [cnt_width-1:0] Mispredict_count
);

    localparam int BHT_N = 1 << index_width;
    localparam int PHT_N = 1 << hist_width;

    // Prediction tables.
    logic [hist_width-1:0] bht_q [BHT_N];
    logic [1:0]            pht_q [PHT_N];

    // State carried from fetch into EX alongside the instruction.
    logic                  pred_ex_q,    pred_ex_d;
    logic [hist_width-1:0] pht_idx_ex_q, pht_idx_ex_d;

    logic [cnt_width-1:0]  mispredict_count_q, mispredict_count_d;

    // Read-side and write-side table addressing.
    logic [index_width-1:0] rd_idx;
    logic [index_width-1:0] wr_idx;
    logic [hist_width-1:0]  rd_hist;
    logic [hist_width-1:0]  bht_old;
    logic [hist_width-1:0]  bht_nxt;
    logic [1:0]             pht_cur;
    logic [1:0]             pht_nxt;

    // Instructions are word aligned and the tables are untagged, so only
    // PC[index_width+1:2] selects an entry; the rest is deliberately ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_ID_PC[31:index_width+2], IF_ID_PC[1:0],
                              ID_EX_PC[31:index_width+2], ID_EX_PC[1:0]};

    assign rd_idx  = IF_ID_PC[index_width+1:2];
    assign wr_idx  = ID_EX_PC[index_width+1:2];

    // Fetch-side lookup: no bypass from the write port, so a same-cycle
    // update is seen by the following lookup, not this one.
    assign rd_hist       = bht_q[rd_idx];
    assign Predict_taken = BTB_hit & pht_q[rd_hist][1];

    // EX-side resolution against the prediction carried with the branch.
    assign Mispredict = ID_EX_Branch & (pred_ex_q != PCSrc);

    // History shift: newest outcome enters at the LSB.
    assign bht_old = bht_q[wr_idx];
    assign bht_nxt = {bht_old[hist_width-2:0], PCSrc};

    // Train the counter selected by the history seen at predict time, not
    // whatever the BHT holds now (later branches may have shifted it).
    assign pht_cur = pht_q[pht_idx_ex_q];

    sat_counter2 u_pht_ctr (
        .cur_i   (pht_cur),
        .taken_i (PCSrc),
        .nxt_o   (pht_nxt)
    );

    // Carry-register next state: a flush bubble wins over a stall hold.
    always_comb begin
        pred_ex_d    = pred_ex_q;
        pht_idx_ex_d = pht_idx_ex_q;
        if (Flush) begin
            pred_ex_d    = 1'b0;
            pht_idx_ex_d = '0;
        end else if (!Stall) begin
            pred_ex_d    = Predict_taken;
            pht_idx_ex_d = rd_hist;
        end
    end

    // Misprediction counter next state: saturates rather than wrapping so a
    // long run never reports a misleadingly small number.
    always_comb begin
        mispredict_count_d = mispredict_count_q;
        if (Mispredict && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + cnt_width'(1);
        end
    end

    // Carry registers and counter update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_ex_q          <= 1'b0;
            pht_idx_ex_q       <= '0;
            mispredict_count_q <= '0;
        end else begin
            pred_ex_q          <= pred_ex_d;
            pht_idx_ex_q       <= pht_idx_ex_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Table training on every resolved conditional branch, regardless of stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= '0;
            end
            for (int j = 0; j < PHT_N; j++) begin
                pht_q[j] <= PHT_RESET;
            end
        end else if (ID_EX_Branch) begin
            bht_q[wr_idx]       <= bht_nxt;
            pht_q[pht_idx_ex_q] <= pht_nxt;
        end
    end

    assign Mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_direction_predictor.sv
// Directed scoreboard bench for branch_direction_predictor.
// A second instance with a 2-bit miss counter runs on the same stimulus so
// counter saturation is reached quickly.
module tb_branch_direction_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic [31:0] ex_pc;
    logic        btb_hit;
    logic        ex_branch;
    logic        pcsrc;
    logic        stall;
    logic        flush;
    logic        pt;
    logic        mp;
    logic [31:0] cnt;
    logic        pt2;
    logic        mp2;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int     step;
        int     ept;
        int     emp;
        longint ecnt;
        int     ecnt2;
        int     tsel;
        int     tidx;
        int     tval;
    } exp_t;

    exp_t exp_q[$];
    int   step_no = 0;

    branch_direction_predictor #(.index_width(8), .hist_width(4), .cnt_width(32)) dut (
        .clk              (clk),
        .reset            (rst_n),
        .IF_ID_PC         (if_pc),
        .ID_EX_PC         (ex_pc),
        .BTB_hit          (btb_hit),
        .ID_EX_Branch     (ex_branch),
        .PCSrc            (pcsrc),
        .Stall            (stall),
        .Flush            (flush),
        .Predict_taken    (pt),
        .Mispredict       (mp),
        .Mispredict_count (cnt)
    );

    branch_direction_predictor #(.index_width(8), .hist_width(4), .cnt_width(2)) dut2 (
        .clk              (clk),
        .reset            (rst_n),
        .IF_ID_PC         (if_pc),
        .ID_EX_PC         (ex_pc),
        .BTB_hit          (btb_hit),
        .ID_EX_Branch     (ex_branch),
        .PCSrc            (pcsrc),
        .Stall            (stall),
        .Flush            (flush),
        .Predict_taken    (pt2),
        .Mispredict       (mp2),
        .Mispredict_count (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int step, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s step %0d got %0d expected %0d", name, step, act, expv);
        end
    endtask

    // One cycle of stimulus: drive after the rising edge, queue what the
    // outputs must look like before the next rising edge.
    task automatic cyc(input logic r, input logic [31:0] ifpc, input logic btb,
                       input logic br, input logic tk, input logic st, input logic fl,
                       input int ept, input int emp, input longint ecnt, input int ecnt2,
                       input int tsel, input int tidx, input int tval);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = r;
        if_pc     = ifpc;
        btb_hit   = btb;
        ex_branch = br;
        pcsrc     = tk;
        stall     = st;
        flush     = fl;
        e.step  = step_no;
        e.ept   = ept;
        e.emp   = emp;
        e.ecnt  = ecnt;
        e.ecnt2 = ecnt2;
        e.tsel  = tsel;
        e.tidx  = tidx;
        e.tval  = tval;
        exp_q.push_back(e);
        step_no++;
    endtask

    // Monitor: compare whatever expectation is pending at each falling edge.
    initial begin
        exp_t        e;
        logic [7:0]  bidx;
        logic [3:0]  pidx;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("Predict_taken", e.step, longint'(pt), longint'(e.ept));
                chk("Predict_taken_n2", e.step, longint'(pt2), longint'(e.ept));
                chk("Mispredict", e.step, longint'(mp), longint'(e.emp));
                chk("Mispredict_count", e.step, longint'(cnt), e.ecnt);
                chk("Mispredict_count_sat2", e.step, longint'(cnt2), longint'(e.ecnt2));
                if (e.tsel == 0) begin
                    bidx = e.tidx[7:0];
                    chk("BHT_entry", e.step, longint'(dut.bht_q[bidx]), longint'(e.tval));
                end else if (e.tsel == 1) begin
                    pidx = e.tidx[3:0];
                    chk("PHT_entry", e.step, longint'(dut.pht_q[pidx]), longint'(e.tval));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog step %0d got timeout expected completion", step_no);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b1; if_pc = '0; ex_pc = 32'h40; btb_hit = 1'b0;
        ex_branch = 1'b0; pcsrc = 1'b0; stall = 1'b0; flush = 1'b0;
        #1 rst_n = 1'b0;
        //   r  IF_PC        btb br tk st fl  pt mp cnt c2  tsel idx val
        cyc(0, 32'h040, 1, 0, 0, 0, 0,  0, 0,  0, 0,  1,  0, 1);
        cyc(0, 32'h040, 1, 1, 1, 0, 0,  0, 1,  0, 0,  1, 15, 1);
        // Train PC 0x40 taken four times, one predict then one resolve each.
        cyc(1, 32'h040, 1, 0, 0, 0, 0,  0, 0,  0, 0,  0, 16, 0);
        cyc(1, 32'h080, 0, 1, 1, 0, 0,  0, 1,  0, 0,  1,  0, 1);
        cyc(1, 32'h040, 1, 0, 0, 0, 0,  0, 0,  1, 1,  1,  0, 2);
        cyc(1, 32'h080, 0, 1, 1, 0, 0,  0, 1,  1, 1,  0, 16, 1);
        cyc(1, 32'h040, 1, 0, 0, 0, 0,  0, 0,  2, 2,  0, 16, 3);
        cyc(1, 32'h080, 0, 1, 1, 0, 0,  0, 1,  2, 2,  1,  1, 2);
        cyc(1, 32'h040, 1, 0, 0, 0, 0,  0, 0,  3, 3,  1,  3, 2);
        cyc(1, 32'h080, 0, 1, 1, 0, 0,  0, 1,  3, 3,  0, 16, 7);
        cyc(1, 32'h040, 1, 0, 0, 0, 0,  0, 0,  4, 3,  0, 16, 15);
        // Push PHT[15] up to strongly taken.
        cyc(1, 32'h080, 0, 1, 1, 0, 0,  0, 1,  4, 3,  1,  7, 2);
        cyc(1, 32'h040, 1, 0, 0, 0, 0,  1, 0,  5, 3,  1, 15, 2);
        cyc(1, 32'h080, 0, 1, 1, 0, 0,  0, 0,  5, 3, -1,  0, 0);
        // BTB gating of the prediction.
        cyc(1, 32'h040, 0, 0, 0, 0, 0,  0, 0,  5, 3,  1, 15, 3);
        cyc(1, 32'h040, 1, 0, 0, 0, 0,  1, 0,  5, 3, -1,  0, 0);
        // Stall holds pred/idx while five not-taken resolves drain PHT[15].
        cyc(1, 32'h100, 1, 1, 0, 1, 0,  1, 1,  5, 3, -1,  0, 0);
        cyc(1, 32'h180, 1, 1, 0, 1, 0,  1, 1,  6, 3,  1, 15, 2);
        cyc(1, 32'h200, 1, 1, 0, 1, 0,  1, 1,  7, 3,  1, 15, 1);
        cyc(1, 32'h240, 1, 1, 0, 1, 0,  1, 1,  8, 3,  1, 15, 0);
        cyc(1, 32'h280, 1, 1, 0, 1, 0,  1, 1,  9, 3,  1, 15, 0);
        cyc(1, 32'h040, 1, 0, 0, 0, 0,  1, 0, 10, 3,  1, 15, 0);
        // Flush beats stall: the carried prediction becomes not-taken.
        cyc(1, 32'h040, 1, 0, 0, 1, 1,  1, 0, 10, 3,  0, 16, 0);
        cyc(1, 32'h080, 0, 1, 1, 0, 0,  0, 1, 10, 3,  1,  0, 2);
        cyc(1, 32'h080, 0, 0, 0, 0, 0,  0, 0, 11, 3,  1,  0, 3);
        cyc(1, 32'h080, 0, 0, 1, 0, 0,  0, 0, 11, 3,  0, 16, 1);
        // Reset in the middle of a training cycle.
        cyc(1, 32'h040, 1, 1, 1, 0, 0,  1, 1, 11, 3,  1,  1, 2);
        @(negedge clk);
        #1 rst_n = 1'b0;
        cyc(0, 32'h040, 1, 1, 1, 0, 0,  0, 1,  0, 0,  0, 16, 0);
        cyc(1, 32'h040, 1, 0, 0, 0, 0,  0, 0,  0, 0,  1,  1, 1);
        cyc(1, 32'h040, 1, 0, 0, 0, 0,  0, 0,  0, 0,  1,  0, 1);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", step_no, longint'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
